// File: rtl/fpu_pkg.sv
// Shared FPU types and constants.
// Used by the add pipe and its neighbours.
package fpu_pkg;

  localparam int FADD_LAT = 4;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  typedef struct packed {
    logic                s;
    logic [FP_EXP_W-1:0] e;
    logic [FP_MAN_W-1:0] m;
  } fp_t;

  typedef enum logic {
    FADD_ADD = 1'b0,
    FADD_SUB = 1'b1
  } fadd_op_e;

  function automatic logic fp_is_zero(input fp_t x);
    return (x.e == '0) && (x.m == '0);
  endfunction

endpackage

// File: rtl/fadd_pipe_if.sv
// Issue-side and writeback-side handshake
// bundle of the FP add pipe.
interface fadd_pipe_if
  import fpu_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int TAG_W = 5
);
  localparam int FW = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic [FW-1:0]    x1;
  logic [FW-1:0]    x2;
  logic             out_valid;
  logic             out_ready;
  logic [FW-1:0]    y;
  logic [TAG_W-1:0] out_tag;
  logic             out_ovf;

  modport master (
    output in_valid, in_sub, in_tag,
    output x1, x2, out_ready,
    input  in_ready, out_valid,
    input  y, out_tag, out_ovf
  );

  modport slave (
    input  in_valid, in_sub, in_tag,
    input  x1, x2, out_ready,
    output in_ready, out_valid,
    output y, out_tag, out_ovf
  );

endinterface

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter.
// All-zero input returns W.
module fpu_lzc #(
  parameter int W = 27
) (
  input  logic [W-1:0]           a,
  output logic [$clog2(W+1)-1:0] cnt
);
  localparam int LW = $clog2(W + 1);

  always_comb begin
    cnt = LW'(W);
    for (int i = 0; i < W; i++) begin
      if (a[i]) cnt = LW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fadd_pipe.sv
// 4-stage RNE float add/sub with valid/ready
// flow control and a pass-through tag.
module fadd_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int TAG_W = 5
) (
  input logic        clk,
  input logic        rst,
  fadd_pipe_if.slave io
);
  localparam int FW = 1 + EXP_W + MAN_W;
  localparam int W  = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam int DW = $clog2(MAN_W + 9);
  localparam int LW = $clog2(W + 1);
  localparam int SW = 2 * MAN_W + 11;

  typedef struct packed {
    logic             s;
    logic             zs;
    logic [EXP_W-1:0] e;
    logic [MAN_W:0]   bm;
    logic [MAN_W:0]   sm;
    logic             sub;
    logic [DW-1:0]    d;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             s;
    logic             zs;
    logic [EW-1:0]    e;
    logic [W:0]       sum;
    logic [TAG_W-1:0] tag;
  } s2_t;

  typedef struct packed {
    logic             s;
    logic             zs;
    logic [EW-1:0]    e;
    logic [W-1:0]     m;
    logic [LW-1:0]    lz;
    logic [TAG_W-1:0] tag;
  } s3_t;

  s1_t r1, n1;
  s2_t r2, n2;
  s3_t r3, n3;
  logic v1, v2, v3;
  logic out_v, ovf_q;
  logic [FW-1:0] y_q;
  logic [TAG_W-1:0] tag_q;
  logic adv;

  assign adv          = !out_v || io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = out_v;
  assign io.y         = y_q;
  assign io.out_tag   = tag_q;
  assign io.out_ovf   = ovf_q;

  // stage 1: unpack, order by magnitude (tie keeps x2)
  fadd_op_e op;
  logic sa, sb, a_big;
  logic [EXP_W-1:0] ea, eb, diff, e1r, e2r;
  logic [MAN_W:0] ma, mb;

  assign op  = fadd_op_e'(io.in_sub);
  assign e1r = io.x1[FW-2 -: EXP_W];
  assign e2r = io.x2[FW-2 -: EXP_W];

  always_comb begin
    sa     = io.x1[FW-1];
    sb     = io.x2[FW-1] ^ (op == FADD_SUB);
    ea     = (e1r == '0) ? EXP_W'(1) : e1r;
    eb     = (e2r == '0) ? EXP_W'(1) : e2r;
    ma     = {e1r != '0, io.x1[MAN_W-1:0]};
    mb     = {e2r != '0, io.x2[MAN_W-1:0]};
    a_big  = {ea, ma} > {eb, mb};
    diff   = a_big ? ea - eb : eb - ea;
    n1.s   = a_big ? sa : sb;
    n1.zs  = sa & sb;
    n1.e   = a_big ? ea : eb;
    n1.bm  = a_big ? ma : mb;
    n1.sm  = a_big ? mb : ma;
    n1.sub = sa ^ sb;
    n1.d   = (int'(diff) > MAN_W + 8) ?
             DW'(MAN_W + 8) : DW'(diff);
    n1.tag = io.in_tag;
  end

  // stage 2: align with guard, round, sticky
  logic [SW-1:0] sh_v;
  logic [W-1:0] al, bg;

  always_comb begin
    sh_v   = {r1.sm, 2'b00, {(MAN_W+8){1'b0}}} >> r1.d;
    al     = {sh_v[SW-1 -: MAN_W+3],
              |sh_v[MAN_W+7:0]};
    bg     = {r1.bm, 3'b000};
    n2.s   = r1.s;
    n2.zs  = r1.zs;
    n2.e   = EW'(r1.e);
    n2.tag = r1.tag;
    n2.sum = r1.sub ? {1'b0, bg} - {1'b0, al}
                    : {1'b0, bg} + {1'b0, al};
  end

  // stage 3: fold carry-out, count leading zeros
  logic [W-1:0] m3;
  logic [LW-1:0] lz3;

  assign m3 = r2.sum[W] ?
              {r2.sum[W:2], |r2.sum[1:0]} :
              r2.sum[W-1:0];

  fpu_lzc #(.W(W)) u_lzc (
    .a   (m3),
    .cnt (lz3)
  );

  always_comb begin
    n3.s   = r2.s;
    n3.zs  = r2.zs;
    n3.e   = r2.e + EW'(r2.sum[W]);
    n3.m   = m3;
    n3.lz  = lz3;
    n3.tag = r2.tag;
  end

  // stage 4: normalise, round, pack
  logic nrm_ok, inc, zero, of;
  logic [W-1:0] norm;
  logic [EW-1:0] en, ef;
  logic [MAN_W+1:0] rm;
  logic [MAN_W-1:0] frac;
  logic [FW-1:0] n_y;
  logic n_ovf;

  always_comb begin
    nrm_ok = r3.e > EW'(r3.lz);
    norm   = nrm_ok ? r3.m << r3.lz
                    : r3.m << (r3.e - EW'(1));
    en     = nrm_ok ? r3.e - EW'(r3.lz) : '0;
    inc    = norm[2] & (norm[1] | norm[0] | norm[3]);
    rm     = {1'b0, norm[W-1:3]} + (MAN_W+2)'(inc);
    frac   = rm[MAN_W+1] ? rm[MAN_W:1]
                         : rm[MAN_W-1:0];
    ef     = (en == '0) ? EW'(rm[MAN_W])
                        : en + EW'(rm[MAN_W+1]);
    zero   = r3.m == '0;
    of     = ef >= EW'({EXP_W{1'b1}});
    n_y    = {r3.s, ef[EXP_W-1:0], frac};
    n_ovf  = 1'b0;
    unique case (1'b1)
      zero: n_y = {r3.zs, {(FW-1){1'b0}}};
      (!zero && of): begin
        n_y   = {r3.s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        n_ovf = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      out_v <= 1'b0;
      y_q   <= '0;
      tag_q <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      v1    <= io.in_valid;
      r1    <= n1;
      v2    <= v1;
      r2    <= n2;
      v3    <= v2;
      r3    <= n3;
      out_v <= v3;
      if (v3) begin
        y_q   <= n_y;
        tag_q <= r3.tag;
        ovf_q <= n_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fadd_pipe.sv
// Scoreboard bench for fadd_pipe against an
// exact wide-integer reference adder.
module tb_fadd_pipe;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fadd_pipe_if io();

  fadd_pipe u_dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  typedef struct packed {
    logic [31:0] y;
    logic [4:0]  tag;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur_exp, got_e;
  int total = 0;
  int bad = 0;
  int npop = 0;
  bit rdy_rand = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h",
               nm, got, want);
    end
  endtask

  function automatic logic [32:0] ref_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic sub);
    fp_t fa, fb;
    logic [299:0] ma, mb, n, q, rem, half;
    logic sa, sb, rs;
    int p, sh, e;
    fa = a;
    fb = b;
    sa = fa.s;
    sb = fb.s ^ sub;
    if (fp_is_zero(fa) && fp_is_zero(fb))
      return {1'b0, sa & sb, 31'd0};
    ma = 300'({fa.e != 8'd0, fa.m});
    mb = 300'({fb.e != 8'd0, fb.m});
    if (fa.e != 8'd0) ma = ma << (int'(fa.e) - 1);
    if (fb.e != 8'd0) mb = mb << (int'(fb.e) - 1);
    if (sa == sb) begin
      n = ma + mb; rs = sa;
    end else if (ma > mb) begin
      n = ma - mb; rs = sa;
    end else if (mb > ma) begin
      n = mb - ma; rs = sb;
    end else begin
      n = '0; rs = 1'b0;
    end
    if (n == '0) return {1'b0, rs, 31'd0};
    p = 0;
    for (int i = 0; i < 300; i++) if (n[i]) p = i;
    if (p <= 23)
      return {1'b0, rs, 7'd0, n[23], n[22:0]};
    sh = p - 23;
    q = n >> sh;
    rem = n & ((300'd1 << sh) - 300'd1);
    half = 300'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0]))
      q = q + 300'd1;
    if (q[24]) begin
      q = q >> 1;
      sh++;
    end
    e = sh + 1;
    if (e >= 255) return {1'b1, rs, 8'hFF, 23'd0};
    return {1'b0, rs, 8'(e), q[22:0]};
  endfunction

  function automatic exp_t mk(input logic [31:0] a,
                              input logic [31:0] b,
                              input logic sub,
                              input logic [4:0] tag);
    logic [32:0] r;
    r = ref_add(a, b, sub);
    return '{r[31:0], tag, r[32]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    v = $urandom();
    case ($urandom_range(0, 3))
      0: v[30:23] = 8'($urandom_range(0, 3));
      1: v[30:23] = 8'($urandom_range(250, 254));
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  // caller sits just after a rising edge
  task automatic send(input logic [31:0] a,
                      input logic [31:0] b,
                      input logic sub,
                      input logic [4:0] tag,
                      input exp_t e);
    int n;
    logic acc;
    n = 0;
    io.in_valid = 1'b1;
    io.x1 = a;
    io.x2 = b;
    io.in_sub = sub;
    io.in_tag = tag;
    cur_exp = e;
    forever begin
      @(negedge clk);
      acc = io.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", n, 0);
        break;
      end
    end
    io.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, sb_q.size(), 0);
  endtask

  task automatic meas_lat(input string nm);
    int lat;
    lat = 1;
    while (!io.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(nm, lat, FADD_LAT);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) begin
      sb_q.delete();
    end else begin
      if (io.out_valid && io.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out", io.out_valid, 1'b0);
        end else begin
          got_e = sb_q.pop_front();
          chk("y", io.y, got_e.y);
          chk("tag", io.out_tag, got_e.tag);
          chk("ovf", io.out_ovf, got_e.ovf);
          npop++;
        end
      end
      if (io.in_valid && io.in_ready)
        sb_q.push_back(cur_exp);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_rand)
      io.out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  localparam int ND = 11;
  logic [31:0] da [ND] = '{
    32'h40400000, 32'h3F800000, 32'h80000000,
    32'h3F800000, 32'h3F800001, 32'h00000001,
    32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00000000,
    32'h00800000, 32'h3F800000};
  logic [31:0] db [ND] = '{
    32'h3F800000, 32'h3F800000, 32'h80000000,
    32'h33800000, 32'h33800000, 32'h00000001,
    32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00000000,
    32'h007FFFFF, 32'hBF800000};
  logic ds [ND] = '{
    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] dy [ND] = '{
    32'h40000000, 32'h00000000, 32'h80000000,
    32'h3F800000, 32'h3F800002, 32'h00000002,
    32'h7F800000, 32'hFF800000, 32'h00000000,
    32'h00000001, 32'h00000000};
  logic dv [ND] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic [31:0] ra, rb, ystall;
  logic rs_b;
  int n0;

  initial begin
    io.in_valid = 1'b0;
    io.in_sub = 1'b0;
    io.in_tag = '0;
    io.x1 = '0;
    io.x2 = '0;
    io.out_ready = 1'b1;
    cur_exp = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_ovalid", io.out_valid, 0);
    chk("rst_y", io.y, 0);
    chk("rst_tag", io.out_tag, 0);
    chk("rst_ovf", io.out_ovf, 0);
    chk("rst_irdy", io.in_ready, 1);

    send(32'h3F800000, 32'h3F800000, 1'b0, 5'd3,
         '{32'h40000000, 5'd3, 1'b0});
    meas_lat("latency");
    drain("drain_first");

    for (int i = 0; i < ND; i++)
      send(da[i], db[i], ds[i], 5'(i),
           '{dy[i], 5'(i), dv[i]});
    drain("drain_dir");

    n0 = npop;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          ra = rnd_fp();
          rb = rnd_fp();
          send(ra, rb, 1'b0, 5'(i),
               mk(ra, rb, 1'b0, 5'(i)));
        end
      end
      begin
        for (int c = 0; c < 14; c++) begin
          io.out_ready = !(c >= 5 && c <= 8);
          @(negedge clk);
          if (c == 5) ystall = io.y;
          if (c >= 5 && c <= 8)
            chk("stall_irdy", io.in_ready, 0);
          if (c >= 6 && c <= 9)
            chk("stall_y", io.y, ystall);
          @(posedge clk);
          #1;
        end
      end
    join
    io.out_ready = 1'b1;
    drain("drain_bp");
    chk("bp_count", npop - n0, 10);

    for (int i = 0; i < 3; i++) begin
      ra = rnd_fp();
      rb = rnd_fp();
      send(ra, rb, 1'b1, 5'(20 + i),
           mk(ra, rb, 1'b1, 5'(20 + i)));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rr_ovalid", io.out_valid, 0);
    chk("rr_y", io.y, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_stale", io.out_valid, 0);
      @(posedge clk);
      #1;
    end
    send(32'h40400000, 32'h3F800000, 1'b1, 5'd7,
         '{32'h40000000, 5'd7, 1'b0});
    meas_lat("rr_latency");
    drain("drain_rr");

    n0 = npop;
    rdy_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      repeat ($urandom_range(0, 3) == 0 ? 1 : 0) begin
        @(posedge clk);
        #1;
      end
      ra = rnd_fp();
      rb = rnd_fp();
      if ($urandom_range(0, 3) == 0)
        rb = {1'($urandom_range(0, 1)),
              ra[30:0] ^ 31'($urandom_range(0, 255))};
      rs_b = 1'($urandom_range(0, 1));
      send(ra, rb, rs_b, 5'(i),
           mk(ra, rb, rs_b, 5'(i)));
    end
    rdy_rand = 1'b0;
    @(posedge clk);
    #1;
    io.out_ready = 1'b1;
    drain("drain_rand");
    chk("rand_count", npop - n0, 1500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
